alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-side front end for the team's 8-bit combinational ALU. It buffers operation commands in a small FIFO, issues them one at a time to the ALU's A/B/sel inputs, and captures y/carry into a registered result. It presents each result on a valid/ready port with carry and zero flags. A chain option lets a command take the previous result as its A operand. It sits between a command producer and the ALU, so an upstream controller never drives the ALU directly.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_a  in  8  operand A (ignored when cmd_chain=1)
- cmd_b  in  8  operand B
- cmd_sel  in  3  ALU opcode: 000 add, 001 sub, 010 mul (low byte), 011 div (/0 gives 0), 100 and, 101 or, 110 xor, 111 not A
- cmd_chain  in  1  use last captured result as A
- alu_a  out  8  registered operand to ALU
- alu_b  out  8  registered operand to ALU
- alu_sel  out  3  registered opcode to ALU
- alu_y  in  8  ALU result (combinational from alu_a/b/sel)
- alu_carry  in  1  ALU carry/borrow
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_y  out  8  captured result
- res_carry  out  1  captured carry
- res_zero  out  1  res_y == 0, registered with res_y
- cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  state != IDLE or FIFO non-empty

## Operation
- Push: a command is written into the FIFO on any edge where cmd_valid && cmd_ready. {a,b,sel,chain} are stored per entry.
- Full FIFO: cmd_ready=0. There is no push-through, even if a pop happens on the same edge.
- Push and pop on the same edge (FIFO not full): both take effect; cmd_count is unchanged.
- FSM states are IDLE, EXEC and WAIT.
  - IDLE: if FIFO is non-empty, pop the head and load alu_a, alu_b, alu_sel, then go to EXEC. alu_a = chain ? last_y : a.
  - EXEC (one cycle): capture alu_y, alu_carry and (alu_y==0) into res_y, res_carry and res_zero. Set res_valid=1, set last_y=alu_y, and go to WAIT.
  - WAIT: hold the res_* outputs. On res_valid && res_ready, clear res_valid. If the FIFO is non-empty, pop and load the ALU regs on the same edge and go to EXEC; otherwise go to IDLE.
- alu_* registers keep their last value outside EXEC.
- Chain: last_y is updated only at EXEC capture. A chained command uses the most recent captured result, whether or not that result has been consumed. After reset, last_y=0.
- res_* outputs are stable while res_valid=1 && res_ready=0.
- The block adds no arithmetic of its own. Carry and zero semantics come entirely from the ALU's outputs.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state=IDLE and FIFO empty, so cmd_ready=1, cmd_count=0 and busy=0.
  - alu_a, alu_b and alu_sel are 0; alu_sel=000 selects add.
  - res_valid, res_y, res_carry and res_zero are 0.
  - last_y is 0.
- Reset mid-operation: queued commands and any in-flight or held result are discarded, with no res_valid pulse.
- Latency, empty and idle: a command accepted at edge T is popped at T+1 and captured at T+2. res_valid is high after edge T+2.
- Throughput: one result every 2 cycles with res_ready held high.
- Backpressure: with res_ready=0, one result is held in WAIT plus DEPTH commands queued. cmd_ready falls once the FIFO is full.

## Test plan
- Reset: assert rst_n=0 mid-burst -> all outputs at reset values immediately; cmd_ready=1 and cmd_count=0 after release.
- Add with carry: a=200, b=100, sel=000 accepted at T -> res_valid after T+2, res_y=44, res_carry=1, res_zero=0.
- Sub borrow and div by zero: (3,5,001) then (9,0,011) -> first result y=254, carry=1; second result y=0, zero=1, carry=0.
- Chain: (5,3,000) then (chain=1, b=8, sel=001) -> results 8 and 0; second has zero=1, carry=0.
- Backpressure: res_ready=0, offer 6 commands back-to-back with DEPTH=4 -> 5 accepted, cmd_ready=0 with cmd_count=4. Raise res_ready -> 5 results in order, one every 2 cycles, with cmd_count stepping down.
- Same-edge push/pop: hold res_ready=1 and cmd_valid=1 with occupancy 2 -> cmd_count stays 2 across pop edges, and no command is lost or duplicated (check against a scoreboard).

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Command / ALU / result signal bundle for alu_sequencer.
// master: command producer, result consumer and the ALU itself.
// slave : the sequencer.
interface alu_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Command push side
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_a;
    logic [7:0]    cmd_b;
    logic [2:0]    cmd_sel;
    logic          cmd_chain;

    // Registered operands to the ALU and its combinational response
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [7:0]    alu_y;
    logic          alu_carry;

    // Result side
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_y;
    logic          res_carry;
    logic          res_zero;

    // Status
    logic [CW-1:0] cmd_count;
    logic          busy;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain,
        output alu_y, alu_carry,
        output res_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        input  res_valid, res_y, res_carry, res_zero,
        input  cmd_count, busy
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain,
        input  alu_y, alu_carry,
        input  res_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        output res_valid, res_y, res_carry, res_zero,
        output cmd_count, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: buffers ALU commands in a small FIFO, issues them one at a
// time to an external combinational ALU, and holds each result on a
// valid/ready port with carry and zero flags. A chained command takes the
// most recently captured result as operand A.
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic       chain;
    } cmd_t;

    // FIFO storage and bookkeeping
    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    cmd_t          head;
    cmd_t          wr_entry;

    // Sequencer state
    state_t        state_q;
    state_t        state_d;
    logic [7:0]    alu_a_q;
    logic [7:0]    alu_a_d;
    logic [7:0]    alu_b_q;
    logic [7:0]    alu_b_d;
    logic [2:0]    alu_sel_q;
    logic [2:0]    alu_sel_d;
    logic          res_valid_q;
    logic          res_valid_d;
    logic [7:0]    res_y_q;
    logic [7:0]    res_y_d;
    logic          res_carry_q;
    logic          res_carry_d;
    logic          res_zero_q;
    logic          res_zero_d;
    logic [7:0]    last_y_q;
    logic [7:0]    last_y_d;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // A full FIFO refuses pushes even when a pop happens on the same edge.
    assign push     = bus.cmd_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign wr_entry = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel, chain: bus.cmd_chain};
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // FIFO payload write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Next-state logic: issue from IDLE/WAIT, capture in EXEC, hold in WAIT
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        last_y_d    = last_y_q;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    alu_a_d   = head.chain ? last_y_q : head.a;
                    alu_b_d   = head.b;
                    alu_sel_d = head.sel;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_y_d     = bus.alu_y;
                res_carry_d = bus.alu_carry;
                res_zero_d  = (bus.alu_y == 8'h00);
                res_valid_d = 1'b1;
                last_y_d    = bus.alu_y;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Issuing the next command on the accept edge gives 2-cycle throughput.
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (!empty) begin
                        pop       = 1'b1;
                        alu_a_d   = head.chain ? last_y_q : head.a;
                        alu_b_d   = head.b;
                        alu_sel_d = head.sel;
                        state_d   = ST_EXEC;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, ALU operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            last_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            last_y_q    <= last_y_d;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.cmd_count = count_q;
    assign bus.busy      = (state_q != ST_IDLE) || !empty;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_y     = res_y_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_sequencer_if #(.DEPTH(4)) bus ();

    alu_sequencer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, y}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), 8'(a - b)};
            3'd2:    return {1'b0, p[7:0]};
            3'd3:    return {1'b0, (b == 8'd0) ? 8'd0 : 8'(a / b)};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    assign {bus.alu_carry, bus.alu_y} = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic ch);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = s;
        bus.cmd_chain = ch;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a result, checks it, then accepts it for one edge.
    task automatic expect_result(input string tag, input logic [7:0] y, input logic c, input logic z);
        int unsigned n;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_y"},     32'(bus.res_y),     32'(y));
        check({tag, "_carry"}, 32'(bus.res_carry), 32'(c));
        check({tag, "_zero"},  32'(bus.res_zero),  32'(z));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] sb[$];
        logic [8:0] m;
        int acc;

        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_sel   = '0;
        bus.cmd_chain = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset values
        check("rst_ready",  32'(bus.cmd_ready), 32'd1);
        check("rst_count",  32'(bus.cmd_count), 32'd0);
        check("rst_busy",   32'(bus.busy),      32'd0);
        check("rst_alu_a",  32'(bus.alu_a),     32'd0);
        check("rst_alu_b",  32'(bus.alu_b),     32'd0);
        check("rst_sel",    32'(bus.alu_sel),   32'd0);
        check("rst_valid",  32'(bus.res_valid), 32'd0);
        check("rst_y",      32'(bus.res_y),     32'd0);
        check("rst_carry",  32'(bus.res_carry), 32'd0);
        check("rst_zero",   32'(bus.res_zero),  32'd0);

        // Add with carry, latency T -> T+2
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'd200;
        bus.cmd_b     = 8'd100;
        bus.cmd_sel   = 3'd0;
        bus.cmd_chain = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        check("add_T_count",   32'(bus.cmd_count), 32'd1);
        check("add_T_valid",   32'(bus.res_valid), 32'd0);
        tick();
        check("add_T1_alu_a",  32'(bus.alu_a),     32'd200);
        check("add_T1_alu_b",  32'(bus.alu_b),     32'd100);
        check("add_T1_sel",    32'(bus.alu_sel),   32'd0);
        check("add_T1_count",  32'(bus.cmd_count), 32'd0);
        check("add_T1_valid",  32'(bus.res_valid), 32'd0);
        check("add_T1_busy",   32'(bus.busy),      32'd1);
        tick();
        check("add_T2_valid",  32'(bus.res_valid), 32'd1);
        check("add_T2_y",      32'(bus.res_y),     32'd44);
        check("add_T2_carry",  32'(bus.res_carry), 32'd1);
        check("add_T2_zero",   32'(bus.res_zero),  32'd0);
        tick();
        check("add_hold_valid", 32'(bus.res_valid), 32'd1);
        check("add_hold_y",     32'(bus.res_y),     32'd44);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("add_acc_valid", 32'(bus.res_valid), 32'd0);
        check("add_acc_busy",  32'(bus.busy),      32'd0);

        // Subtract with borrow, then divide by zero
        push(8'd3, 8'd5, 3'd1, 1'b0);
        push(8'd9, 8'd0, 3'd3, 1'b0);
        expect_result("sub", 8'd254, 1'b1, 1'b0);
        expect_result("div0", 8'd0, 1'b0, 1'b1);
        check("div0_busy", 32'(bus.busy), 32'd0);

        // Chain: 5+3=8, then 8-8=0
        push(8'd5, 8'd3, 3'd0, 1'b0);
        push(8'hAA, 8'd8, 3'd1, 1'b1);
        expect_result("chain1", 8'd8, 1'b0, 1'b0);
        check("chain_alu_a", 32'(bus.alu_a), 32'd8);
        expect_result("chain2", 8'd0, 1'b0, 1'b1);

        // Backpressure: 6 offered, 5 accepted (1 held + 4 queued)
        acc = 0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_a     = 8'(10 * (i + 1));
            bus.cmd_b     = 8'(i + 1);
            bus.cmd_sel   = 3'd0;
            bus.cmd_chain = 1'b0;
            if (bus.cmd_ready === 1'b1) acc++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc),           32'd5);
        check("bp_ready",    32'(bus.cmd_ready), 32'd0);
        check("bp_count",    32'(bus.cmd_count), 32'd4);
        check("bp_valid",    32'(bus.res_valid), 32'd1);
        check("bp_y0",       32'(bus.res_y),     32'd11);
        bus.res_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("bp_gap%0d_valid", k), 32'(bus.res_valid), 32'd0);
            check($sformatf("bp_gap%0d_count", k), 32'(bus.cmd_count), 32'(4 - k));
            check($sformatf("bp_gap%0d_ready", k), 32'(bus.cmd_ready), 32'd1);
            tick();
            check($sformatf("bp_res%0d_valid", k), 32'(bus.res_valid), 32'd1);
            check($sformatf("bp_res%0d_y", k),     32'(bus.res_y),     32'(11 * (k + 1)));
        end
        tick();
        bus.res_ready = 1'b0;
        check("bp_end_valid", 32'(bus.res_valid), 32'd0);
        check("bp_end_count", 32'(bus.cmd_count), 32'd0);
        check("bp_end_busy",  32'(bus.busy),      32'd0);

        // Same-edge push/pop at occupancy 2, checked against a scoreboard
        bus.cmd_valid = 1'b1;
        bus.cmd_chain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_a   = 8'(i * 37 + 5);
            bus.cmd_b   = 8'(i * 3 + 1);
            bus.cmd_sel = 3'(i);
            tick();
            sb.push_back(alu_f(8'(i * 37 + 5), 8'(i * 3 + 1), 3'(i)));
        end
        bus.cmd_valid = 1'b0;
        check("pp_setup_count", 32'(bus.cmd_count), 32'd2);
        check("pp_setup_valid", 32'(bus.res_valid), 32'd1);
        for (int i = 3; i < 9; i++) begin
            bus.cmd_a     = 8'(i * 37 + 5);
            bus.cmd_b     = 8'(i * 3 + 1);
            bus.cmd_sel   = 3'(i);
            bus.cmd_valid = 1'b1;
            bus.res_ready = 1'b1;
            m = sb.pop_front();
            check($sformatf("pp%0d_valid", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("pp%0d_y", i),     32'(bus.res_y),     32'(m[7:0]));
            check($sformatf("pp%0d_carry", i), 32'(bus.res_carry), 32'(m[8]));
            tick();
            sb.push_back(alu_f(8'(i * 37 + 5), 8'(i * 3 + 1), 3'(i)));
            bus.cmd_valid = 1'b0;
            check($sformatf("pp%0d_count", i), 32'(bus.cmd_count), 32'd2);
            tick();
        end
        bus.res_ready = 1'b0;
        while (sb.size() > 0) begin
            m = sb.pop_front();
            expect_result("pp_drain", m[7:0], m[8], (m[7:0] == 8'd0));
        end
        check("pp_end_busy", 32'(bus.busy), 32'd0);

        // Reset mid-operation: held result and queue discarded, last_y cleared
        push(8'd1, 8'd1, 3'd0, 1'b0);
        push(8'd2, 8'd2, 3'd0, 1'b0);
        push(8'd3, 8'd3, 3'd0, 1'b0);
        check("mid_pre_valid", 32'(bus.res_valid), 32'd1);
        check("mid_pre_y",     32'(bus.res_y),     32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_count", 32'(bus.cmd_count), 32'd0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_alu_a", 32'(bus.alu_a),     32'd0);
        check("mid_rst_y",     32'(bus.res_y),     32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_count", 32'(bus.cmd_count), 32'd0);
        check("mid_rel_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rel_valid", 32'(bus.res_valid), 32'd0);
        tick();
        check("mid_rel_valid2", 32'(bus.res_valid), 32'd0);
        push(8'h77, 8'd5, 3'd0, 1'b1);
        expect_result("post_rst_chain", 8'd5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
